mips_multicycle_core: RTL and testbench

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

---
 rtl/mips_pkg.sv | 85 ++++++++
 rtl/mips_mc_register_file.sv | 34 +++
 rtl/mips_multicycle_core.sv | 181 ++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, function codes,
// FSM state encoding, ALU operation codes and small decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_t;

  function automatic logic is_supported(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_SUB,
          FN_AND, FN_OR, FN_NOR, FN_SLT: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Branches use SUB so ALUOut holds the comparison difference.
  function automatic alu_op_t alu_op_for(input logic [5:0] opcode, input logic [5:0] funct);
    alu_op_t op;
    op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_NOR:  op = ALU_NOR;
          FN_SLT:  op = ALU_SLT;
          FN_SLL:  op = ALU_SLL;
          FN_SRL:  op = ALU_SRL;
          default: op = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: op = ALU_SUB;
      OP_ANDI:        op = ALU_AND;
      OP_ORI:         op = ALU_OR;
      OP_LUI:         op = ALU_LUI;
      default:        op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_mc_register_file.sv
// 32x32 register file: two asynchronous reads, one synchronous write,
// asynchronous active-low reset with $sp preset. r0 is hardwired to zero.
module mips_mc_register_file
  import mips_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 29) ? SP_INIT : 32'd0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK FSM with a
// single shared memory port and an absorbing TRAP state for faults.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] SP_INIT  = 32'h7FFF_EFFC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] alu_result_o,
  output logic [2:0]  state_o,
  output logic        trap_o
);

  state_t      state;
  logic        run;
  logic [31:0] pc, ir, a, b, imm, alu_out, mdr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_y, alu_src_b;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  alu_op_t     alu_op;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic       fetch_misaligned, mem_misaligned;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];

  assign fetch_misaligned = (pc[1:0] != 2'b00);
  assign mem_misaligned   = (alu_out[1:0] != 2'b00);

  mips_mc_register_file #(.SP_INIT(SP_INIT)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs),
    .raddr_b (rt),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  // run stays low until the first edge after reset, so no request is visible during reset.
  assign mem_req_o   = run && (((state == S_FETCH) && !fetch_misaligned) ||
                               ((state == S_MEM) && !mem_misaligned));
  assign mem_we_o    = (state == S_MEM) && (opcode == OP_SW);
  assign mem_addr_o  = (state == S_MEM) ? alu_out : pc;
  assign mem_wdata_o = b;
  assign alu_result_o = alu_out;
  assign state_o      = state;
  assign trap_o       = (state == S_TRAP);

  assign alu_op    = alu_op_for(opcode, funct);
  assign alu_src_b = ((opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE)) ? b : imm;

  always_comb begin
    alu_y = 32'd0;
    case (alu_op)
      ALU_ADD: alu_y = a + alu_src_b;
      ALU_SUB: alu_y = a - alu_src_b;
      ALU_AND: alu_y = a & alu_src_b;
      ALU_OR:  alu_y = a | alu_src_b;
      ALU_NOR: alu_y = ~(a | alu_src_b);
      ALU_SLT: alu_y = {31'd0, ($signed(a) < $signed(alu_src_b))};
      ALU_SLL: alu_y = b << shamt;
      ALU_SRL: alu_y = b >> shamt;
      ALU_LUI: alu_y = {imm[15:0], 16'd0};
      default: alu_y = 32'd0;
    endcase
  end

  // jal links in EXECUTE using the already-incremented PC.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if ((state == S_EXECUTE) && (opcode == OP_JAL)) begin
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      rf_wdata = pc;
    end else if (state == S_WRITEBACK) begin
      rf_we    = 1'b1;
      rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
      rf_wdata = (opcode == OP_LW) ? mdr : alu_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      run     <= 1'b0;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      imm     <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FETCH: begin
          if (run) begin
            if (fetch_misaligned) begin
              state <= S_TRAP;
            end else if (mem_ready_i) begin
              ir    <= mem_rdata_i;
              pc    <= pc + 32'd4;
              state <= S_DECODE;
            end
          end
        end
        S_DECODE: begin
          a     <= rs_data;
          b     <= rt_data;
          imm   <= ((opcode == OP_ORI) || (opcode == OP_ANDI)) ?
                   {16'd0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
          state <= is_supported(opcode, funct) ? S_EXECUTE : S_TRAP;
        end
        S_EXECUTE: begin
          alu_out <= alu_y;
          case (opcode)
            OP_BEQ: begin
              if (a == b) pc <= pc + {imm[29:0], 2'b00};
              state <= S_FETCH;
            end
            OP_BNE: begin
              if (a != b) pc <= pc + {imm[29:0], 2'b00};
              state <= S_FETCH;
            end
            OP_J, OP_JAL: begin
              pc    <= {pc[31:28], ir[25:0], 2'b00};
              state <= S_FETCH;
            end
            OP_LW, OP_SW: state <= S_MEM;
            OP_RTYPE: begin
              if (funct == FN_JR) begin
                pc    <= a;
                state <= S_FETCH;
              end else begin
                state <= S_WRITEBACK;
              end
            end
            default: state <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          if (mem_misaligned) begin
            state <= S_TRAP;
          end else if (mem_ready_i) begin
            if (opcode == OP_LW) begin
              mdr   <= mem_rdata_i;
              state <= S_WRITEBACK;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_WRITEBACK: state <= S_FETCH;
        S_TRAP:      state <= S_TRAP;
        default:     state <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a small program in a word array
// exercises ALU ops, loads/stores, branches, jumps, fault trapping and reset.
module tb_mips_multicycle_core;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] SP_INIT  = 32'h7FFF_EFFC;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] alu_result;
  logic [2:0]  state;
  logic        trap;

  logic [31:0] imem [64];
  logic [31:0] dword;
  logic [31:0] wr_addr, wr_data;
  int          wr_count;
  int          req_seen;
  int          errors;
  int          checks;

  mips_multicycle_core #(.RESET_PC(RESET_PC), .SP_INIT(SP_INIT)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ready_i  (mem_ready),
    .mem_rdata_i  (mem_rdata),
    .alu_result_o (alu_result),
    .state_o      (state),
    .trap_o       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr[31:8] == 24'h004000) ? imem[mem_addr[7:2]] :
                     (mem_addr == SP_INIT) ? dword : 32'd0;

  always @(posedge clk) begin
    if (mem_req) req_seen <= req_seen + 1;
    if (mem_req && mem_we && mem_ready) begin
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
      wr_count <= wr_count + 1;
      if (mem_addr == SP_INIT) dword <= mem_wdata;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Steps until the next fetch request and checks the cycle count and address.
  task automatic run_instr(input string tag, input int exp_cycles, input logic [31:0] exp_addr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((state == 3'd0) && mem_req) && (n < 40));
    check_output({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    check_output({tag, "_next_fetch"}, mem_addr, exp_addr);
  endtask

  task automatic apply_stimulus(input logic rst_level, input logic ready_level);
    reset     = rst_level;
    mem_ready = ready_level;
  endtask

  initial begin
    int snap;
    errors = 0;
    checks = 0;
    wr_count = 0;
    req_seen = 0;
    wr_addr = 32'd0;
    wr_data = 32'd0;
    dword = 32'd0;
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    imem[0] = 32'h2008_0005;  // addi $t0,$zero,5
    imem[1] = 32'h2108_0002;  // addi $t0,$t0,2
    imem[2] = 32'hAFA8_0000;  // sw   $t0,0($sp)
    imem[3] = 32'h8FA9_0000;  // lw   $t1,0($sp)
    imem[4] = 32'h1108_FFFF;  // beq  $t0,$t0,-1
    imem[5] = 32'h3C0B_8000;  // lui  $t3,0x8000
    imem[6] = 32'h0168_602A;  // slt  $t4,$t3,$t0
    imem[7] = 32'h0008_6822;  // sub  $t5,$zero,$t0
    imem[8] = 32'h0C10_0000;  // jal  0x0100000

    apply_stimulus(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check_output("reset_req", 32'(mem_req), 32'd0);
    check_output("reset_state", 32'(state), 32'd0);
    check_output("reset_trap", 32'(trap), 32'd0);
    check_output("reset_alu", alu_result, 32'd0);
    check_output("reset_pc", u_dut.pc, RESET_PC);
    check_output("reset_sp", u_dut.u_regfile.regs[29], SP_INIT);

    apply_stimulus(1'b1, 1'b1);
    check_output("release_no_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check_output("first_fetch_req", 32'(mem_req), 32'd1);
    check_output("first_fetch_addr", mem_addr, 32'h0040_0000);

    @(negedge clk);
    check_output("addi_decode", 32'(state), 32'd1);
    @(negedge clk);
    check_output("addi_execute", 32'(state), 32'd2);
    @(negedge clk);
    check_output("addi_writeback", 32'(state), 32'd4);
    check_output("addi_alu", alu_result, 32'd5);
    @(negedge clk);
    check_output("addi_r8", u_dut.u_regfile.regs[8], 32'd5);
    check_output("addi_next_fetch", mem_addr, 32'h0040_0004);

    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stall_state", 32'(state), 32'd0);
      check_output("stall_addr", mem_addr, 32'h0040_0004);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check_output("stall_ir_loaded", u_dut.ir, 32'h2108_0002);
    run_instr("addi2", 3, 32'h0040_0008);
    check_output("addi2_r8", u_dut.u_regfile.regs[8], 32'd7);

    run_instr("sw", 4, 32'h0040_000C);
    check_output("sw_count", 32'(wr_count), 32'd1);
    check_output("sw_addr", wr_addr, 32'h7FFF_EFFC);
    check_output("sw_data", wr_data, 32'd7);
    run_instr("lw", 5, 32'h0040_0010);
    check_output("lw_r9", u_dut.u_regfile.regs[9], 32'd7);

    run_instr("beq_taken", 3, 32'h0040_0010);
    imem[4] = 32'h1508_FFFF;  // bne $t0,$t0,-1 replaces the loop before refetch
    run_instr("bne_not_taken", 3, 32'h0040_0014);

    run_instr("lui", 4, 32'h0040_0018);
    check_output("lui_alu", alu_result, 32'h8000_0000);
    run_instr("slt", 4, 32'h0040_001C);
    check_output("slt_signed", u_dut.u_regfile.regs[12], 32'd1);
    run_instr("sub", 4, 32'h0040_0020);
    check_output("sub_wrap", alu_result, 32'hFFFF_FFF9);

    imem[0] = 32'h3C0E_0040;  // lui  $t6,0x0040
    imem[1] = 32'h316F_FFFF;  // andi $t7,$t3,0xFFFF
    imem[2] = 32'h35CE_0002;  // ori  $t6,$t6,2
    imem[3] = 32'h01C0_0008;  // jr   $t6
    run_instr("jal", 3, 32'h0040_0000);
    check_output("jal_r31", u_dut.u_regfile.regs[31], 32'h0040_0024);
    run_instr("lui2", 4, 32'h0040_0004);
    run_instr("andi_zext", 4, 32'h0040_0008);
    check_output("andi_alu", alu_result, 32'd0);
    run_instr("ori", 4, 32'h0040_000C);
    check_output("ori_r14", u_dut.u_regfile.regs[14], 32'h0040_0002);

    repeat (3) @(negedge clk);
    check_output("jr_fetch_state", 32'(state), 32'd0);
    check_output("jr_misaligned_no_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check_output("trap_state", 32'(state), 32'd5);
    check_output("trap_flag", 32'(trap), 32'd1);
    check_output("trap_pc", u_dut.pc, 32'h0040_0002);
    snap = req_seen;
    repeat (5) @(negedge clk);
    check_output("trap_absorbing", 32'(state), 32'd5);
    check_output("trap_no_req", 32'(req_seen - snap), 32'd0);

    reset = 1'b0;
    #1;
    check_output("trap_reset_flag", 32'(trap), 32'd0);
    imem[0] = 32'hAFA8_0000;  // sw $t0,0($sp) with $t0 cleared by reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("restart_fetch", mem_addr, RESET_PC);
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("mem_state", 32'(state), 32'd3);
    check_output("mem_req", 32'(mem_req), 32'd1);
    check_output("mem_we", 32'(mem_we), 32'd1);
    check_output("mem_addr", mem_addr, SP_INIT);
    check_output("mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    check_output("mem_stalled", 32'(state), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_req_drop", 32'(mem_req), 32'd0);
    check_output("async_state", 32'(state), 32'd0);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b1);
    check_output("async_pc", u_dut.pc, RESET_PC);
    @(negedge clk);
    check_output("post_reset_fetch_req", 32'(mem_req), 32'd1);
    check_output("post_reset_fetch_addr", mem_addr, RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
